// File: rtl/mips_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide unit.
package mips_pkg;

    // Counter width able to hold the iteration index for a given operand width.
    function automatic int unsigned muldiv_cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned MULDIV_WIDTH = 32;
    localparam int unsigned MULDIV_CNT_W = muldiv_cnt_w(MULDIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used to take operand magnitudes at
// start and to restore result signs when committing.
//   val_i : value to condition
//   neg_i : 1 = return -val_i, 0 = pass through
//   res_o : conditioned value (combinational)
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One multiplier bit (shift-add) or one quotient bit (restoring) per cycle,
// followed by a single sign-fix/commit cycle.
//   clk, reset       : clock, asynchronous active-low reset
//   startE           : launch an operation (ignored while busy)
//   divE, signedE    : operation select and signedness
//   srcaE, srcbE     : multiplicand/dividend, multiplier/divisor
//   mthiW, mtloW     : move-to-HI/LO writes with data wdataW
//   busy             : operation in flight (includes the commit cycle)
//   done             : one-cycle pulse after HI/LO were committed
//   hi, lo           : committed HI/LO
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic             divE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiW,
    input  logic             mtloW,
    input  logic [WIDTH-1:0] wdataW,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = muldiv_cnt_w(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             div_q, div_d;
    logic             divz_q, divz_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_shift_c, div_diff_c;
    logic             div_fits_c;
    logic             last_iter_c;
    logic             res_neg_c;

    // Operand magnitudes; unsigned operations pass through unchanged.
    muldiv_signfix #(.W(WIDTH)) u_mag_a (
        .val_i (srcaE),
        .neg_i (signedE & srcaE[WIDTH-1]),
        .res_o (mag_a_c)
    );

    muldiv_signfix #(.W(WIDTH)) u_mag_b (
        .val_i (srcbE),
        .neg_i (signedE & srcbE[WIDTH-1]),
        .res_o (mag_b_c)
    );

    // Result sign restoration; the sign flags are zero for unsigned operations.
    assign res_neg_c = neg_a_q ^ neg_b_q;

    muldiv_signfix #(.W(PW)) u_fix_prod (
        .val_i (prod_q),
        .neg_i (res_neg_c),
        .res_o (prod_fix_c)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i (quo_q),
        .neg_i (res_neg_c),
        .res_o (quo_fix_c)
    );

    // Remainder follows the dividend's sign.
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i (rem_q[WIDTH-1:0]),
        .neg_i (neg_a_q),
        .res_o (rem_fix_c)
    );

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, consuming one multiplier bit.
    assign mul_sum_c = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // A set top remainder bit means the shifted value certainly exceeds the divisor.
    assign div_shift_c = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, opb_q};
    assign div_fits_c  = rem_q[WIDTH] | ~div_diff_c[WIDTH];

    assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div_q   <= 1'b0;
            divz_q  <= 1'b0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            div_q   <= div_d;
            divz_q  <= divz_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, iteration datapath and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        div_d   = div_q;
        divz_d  = divz_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // Move-to writes land in any state; a commit below takes priority.
        if (mthiW) hi_d = wdataW;
        if (mtloW) lo_d = wdataW;

        unique case (state_q)
            IDLE: begin
                if (startE) begin
                    state_d = divE ? DIV : MUL;
                    cnt_d   = '0;
                    opa_d   = mag_a_c;
                    opb_d   = mag_b_c;
                    neg_a_d = signedE & srcaE[WIDTH-1];
                    neg_b_d = signedE & srcbE[WIDTH-1];
                    div_d   = divE;
                    divz_d  = (srcbE == '0);
                    prod_d  = {{WIDTH{1'b0}}, mag_b_c};
                    rem_d   = '0;
                    quo_d   = mag_a_c;
                end
            end
            MUL: begin
                prod_d = {mul_sum_c, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter_c) state_d = FIX;
            end
            DIV: begin
                rem_d = div_fits_c ? div_diff_c : div_shift_c;
                quo_d = {quo_q[WIDTH-2:0], div_fits_c};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter_c) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (div_q) begin
                    // Divide by zero leaves the dividend in HI and all ones in LO.
                    hi_d = rem_fix_c;
                    lo_d = divz_q ? '1 : quo_fix_c;
                end else begin
                    hi_d = prod_fix_c[PW-1:WIDTH];
                    lo_d = prod_fix_c[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered status outputs.
    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q == FIX);

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers; sits in EX beside the ALU.
- Consumes the controller's EX-stage mult/div decode (start, mult-vs-div, signedness) and WB-stage move-to-HI/LO writes.
- Reports busy to the hazard unit, which stalls any mfhi/mflo/mult/div/mthi/mtlo that reaches the unit while busy=1.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
startE  in  1  accept a new operation this cycle; already qualified by the controller's multordivE & hlwriteE and not flushE.
divE  in  1  0 = multiply, 1 = divide.
signedE  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu).
srcaE  in  WIDTH  multiplicand or dividend.
srcbE  in  WIDTH  multiplier or divisor.
mthiW  in  1  write HI from wdataW.
mtloW  in  1  write LO from wdataW.
wdataW  in  WIDTH  move-to data.
busy  out  1  operation in flight.
done  out  1  one-cycle pulse: HI/LO committed this cycle.
hi  out  WIDTH  committed HI.
lo  out  WIDTH  committed LO.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi, lo, busy, done = 0; all datapath registers cleared. Reset mid-operation discards the operation; HI/LO read 0 afterwards.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL or DIV on startE (selected by divE).
  - MUL/DIV -> FIX after WIDTH iterations; FIX -> IDLE unconditionally.
- Start: startE sampled at edge ending cycle N.
  - Latches |srca| and |srcb| (magnitudes when signedE=1, raw values otherwise).
  - Latches result-sign flags and divE; clears the iteration counter.
- Latency:
  - busy=1 in cycles N+1..N+WIDTH+1 (WIDTH iterations plus FIX; 33 cycles at default).
  - hi/lo update at the edge ending cycle N+WIDTH+1.
  - done=1 and busy=0 in cycle N+WIDTH+2.
- MUL: radix-2 shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- DIV: restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- FIX (signed only):
  - Product negated if exactly one operand was negative.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Commits HI = product[2W-1:W] / remainder and LO = product[W-1:0] / quotient.
- Edge cases:
  - Divide by zero (any signedness): HI = srcaE as latched (original value), LO = all ones. Full iteration latency is still taken; no early exit.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, wrapping naturally; no trap.
- startE while busy: ignored, with no effect on the in-flight operation (the hazard unit must prevent this).
- mthiW/mtloW:
  - Write at the edge when not busy; both may assert together.
  - During busy, writes update hi/lo immediately but are overwritten at commit.
  - A write on the commit edge loses to the commit.
- startE and mthiW/mtloW in the same IDLE cycle: the move writes and the operation starts. The operation's later commit overwrites the moved value.
- hi/lo are registered outputs that never show partial results. WB-side forwarding of hi/lo is the datapath's job.

Decomposition:
- Shared package mips_pkg holds:
  - muldiv_state_t enum (IDLE, MUL, DIV, FIX);
  - the iteration-counter width localparam, $clog2(WIDTH)+1.
- One natural sub-module: muldiv_signfix, the combinational magnitude/negate helper used at both start and FIX.
- Everything else lives in hilo_muldiv.

Test Plan:
- Signed mult 7 x 0xFFFFFFFD -> after 33 busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once in cycle N+34.
- Unsigned multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary divides:
  - divu 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, 33 busy cycles.
  - Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x1234 while idle -> hi=0x1234 next cycle. Then start mult 3 x 4 and mtlo 0xAAAA during busy -> final lo=12, hi=0.
- Assert reset=0 at iteration 10 of a div -> busy, done, hi, lo all 0 immediately. Release reset, then startE=1 with no operands changed -> a fresh 33-cycle operation completes correctly.
